// File: rtl/friscv_axi_rsp_ordering_pkg.sv
// Shared width helpers and table-entry type for the AXI response ordering guard.
// The FRISCV_RSP_HAZARD_EN macro selects hazard tracking in the users of this package.
package friscv_axi_rsp_ordering_pkg;

  function automatic int addr_lsb(input int block_w);
    return $clog2(block_w / 8);
  endfunction

  function automatic int tag_width(input int addr_w, input int block_w);
    return addr_w - addr_lsb(block_w);
  endfunction

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_BLOCK_W = 128;
  localparam int DEF_TAG_W   = tag_width(DEF_ADDR_W, DEF_BLOCK_W);

  // Table entry at the default address/block geometry.
  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/friscv_tag_fifo.sv
// Circular tracking FIFO of block tags with sticky overflow/underflow and a seek port.
// Tag storage and the seek compare exist only when FRISCV_RSP_HAZARD_EN is defined.
module friscv_tag_fifo
  import friscv_axi_rsp_ordering_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = DEF_TAG_W,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  logic             pull_i,
  input  logic [TAG_W-1:0] seek_tag_i,
  output logic             seek_hit_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int IDX_W = PTR_W - 1;

`ifdef FRISCV_RSP_HAZARD_EN
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } entry_t;
`else
  typedef struct packed {
    logic valid;
  } entry_t;
`endif

  entry_t           tab_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             overflow_q, underflow_q;
  logic             do_push, do_pull;

  // MSB differing with equal index bits means the writer has lapped the reader.
  assign full_o   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign count_o  = wr_ptr_q - rd_ptr_q;
  assign do_push  = push_i && !full_o;
  assign do_pull  = pull_i && !empty_o;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tab_q[i] <= '0;
    end else begin
      if (push_i && full_o) overflow_q <= 1'b1;
      if (pull_i && empty_o) underflow_q <= 1'b1;
      if (do_pull) begin
        tab_q[rd_ptr_q[IDX_W-1:0]].valid <= 1'b0;
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push) begin
        tab_q[wr_ptr_q[IDX_W-1:0]].valid <= 1'b1;
`ifdef FRISCV_RSP_HAZARD_EN
        tab_q[wr_ptr_q[IDX_W-1:0]].tag <= push_tag_i;
`endif
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

`ifdef FRISCV_RSP_HAZARD_EN
  // Compare against registered contents, so an entry retiring this cycle still hits.
  always_comb begin
    seek_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tab_q[i].valid && (tab_q[i].tag == seek_tag_i)) seek_hit_o = 1'b1;
    end
  end
`else
  logic             unused_tags;
  logic [DEPTH-1:0] unused_valid;

  assign seek_hit_o  = 1'b0;
  assign unused_tags = ^{push_tag_i, seek_tag_i};
  always_comb begin
    unused_valid = '0;
    for (int i = 0; i < DEPTH; i++) unused_valid[i] = tab_q[i].valid;
  end
`endif

endmodule

// File: rtl/friscv_axi_rsp_ordering.sv
// Responder-side AXI4 ordering guard: tracks outstanding writes/reads per block and gates AW/AR.
// Define FRISCV_RSP_HAZARD_EN to gate on read/write block hazards; otherwise only on full.
module friscv_axi_rsp_ordering
  import friscv_axi_rsp_ordering_pkg::*;
#(
  parameter int MAX_OR      = 8,
  parameter int AXI_ADDR_W  = 32,
  parameter int MEM_BLOCK_W = 128,
  parameter int CNT_W       = $clog2(MAX_OR) + 1
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  awvalid,
  input  logic                  awready,
  input  logic [AXI_ADDR_W-1:0] awaddr,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic [AXI_ADDR_W-1:0] araddr,
  input  logic                  bvalid,
  input  logic                  bready,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic                  rlast,
  output logic                  aw_grant,
  output logic                  ar_grant,
  output logic [CNT_W-1:0]      wr_or_cnt,
  output logic [CNT_W-1:0]      rd_or_cnt,
  output logic                  pending_wr,
  output logic                  pending_rd,
  output logic                  err
);

  localparam int ADDR_LSB = addr_lsb(MEM_BLOCK_W);
  localparam int TAG_W    = tag_width(AXI_ADDR_W, MEM_BLOCK_W);

  // A handshake is valid&ready on the slave side of the gate; R retires only on its last beat.
  logic             wr_push, wr_pull, rd_push, rd_pull;
  logic             wr_full, rd_full, wr_empty, rd_empty;
  logic             wr_ovf, wr_udf, rd_ovf, rd_udf;
  logic             war_hit, raw_hit;
  logic [TAG_W-1:0] aw_tag, ar_tag;
  logic             unused_addr_lsb;

  assign wr_push = awvalid && awready;
  assign wr_pull = bvalid && bready;
  assign rd_push = arvalid && arready;
  assign rd_pull = rvalid && rready && rlast;
  assign aw_tag  = awaddr[AXI_ADDR_W-1:ADDR_LSB];
  assign ar_tag  = araddr[AXI_ADDR_W-1:ADDR_LSB];
  assign unused_addr_lsb = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  friscv_tag_fifo #(.DEPTH(MAX_OR), .TAG_W(TAG_W), .PTR_W(CNT_W)) u_wr_tab (
    .clk_i       (aclk),
    .rst_i       (arst),
    .push_i      (wr_push),
    .push_tag_i  (aw_tag),
    .pull_i      (wr_pull),
    .seek_tag_i  (ar_tag),
    .seek_hit_o  (raw_hit),
    .full_o      (wr_full),
    .empty_o     (wr_empty),
    .count_o     (wr_or_cnt),
    .overflow_o  (wr_ovf),
    .underflow_o (wr_udf)
  );

  friscv_tag_fifo #(.DEPTH(MAX_OR), .TAG_W(TAG_W), .PTR_W(CNT_W)) u_rd_tab (
    .clk_i       (aclk),
    .rst_i       (arst),
    .push_i      (rd_push),
    .push_tag_i  (ar_tag),
    .pull_i      (rd_pull),
    .seek_tag_i  (aw_tag),
    .seek_hit_o  (war_hit),
    .full_o      (rd_full),
    .empty_o     (rd_empty),
    .count_o     (rd_or_cnt),
    .overflow_o  (rd_ovf),
    .underflow_o (rd_udf)
  );

  assign aw_grant   = !wr_full && !war_hit;
  assign ar_grant   = !rd_full && !raw_hit;
  assign pending_wr = !wr_empty;
  assign pending_rd = !rd_empty;
  assign err        = wr_ovf || wr_udf || rd_ovf || rd_udf;

endmodule

// File: tb/tb_friscv_axi_rsp_ordering.sv
// Directed bench for friscv_axi_rsp_ordering (MAX_OR=8, 16-byte blocks).
// Hazard expectations follow whether FRISCV_RSP_HAZARD_EN is defined for the build.
module tb_friscv_axi_rsp_ordering;

`ifdef FRISCV_RSP_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        awvalid = 1'b0, awready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        arvalid = 1'b0, arready = 1'b0;
  logic [31:0] araddr = '0;
  logic        bvalid = 1'b0, bready = 1'b0;
  logic        rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;
  logic        aw_grant, ar_grant, pending_wr, pending_rd, err;
  logic [3:0]  wr_or_cnt, rd_or_cnt;

  int tests = 0;
  int fails = 0;

  // Scoreboard: block tags of outstanding transactions in issue order.
  logic [27:0] exp_wr_q[$];
  logic [27:0] exp_rd_q[$];

  friscv_axi_rsp_ordering #(.MAX_OR(8), .AXI_ADDR_W(32), .MEM_BLOCK_W(128)) dut (
    .aclk       (aclk),
    .arst       (arst),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .bvalid     (bvalid),
    .bready     (bready),
    .rvalid     (rvalid),
    .rready     (rready),
    .rlast      (rlast),
    .aw_grant   (aw_grant),
    .ar_grant   (ar_grant),
    .wr_or_cnt  (wr_or_cnt),
    .rd_or_cnt  (rd_or_cnt),
    .pending_wr (pending_wr),
    .pending_rd (pending_rd),
    .err        (err)
  );

  // Clock and watchdog
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    awvalid = 1'b0; awready = 1'b0;
    arvalid = 1'b0; arready = 1'b0;
    bvalid  = 1'b0; bready  = 1'b0;
    rvalid  = 1'b0; rready  = 1'b0; rlast = 1'b0;
  endtask

  task automatic aw_push(input logic [31:0] addr);
    awvalid = 1'b1; awready = 1'b1; awaddr = addr;
    check("aw_grant_on_push", {31'd0, aw_grant}, 32'd1);
    tick();
    exp_wr_q.push_back(addr[31:4]);
    awvalid = 1'b0; awready = 1'b0;
  endtask

  task automatic ar_push(input logic [31:0] addr);
    arvalid = 1'b1; arready = 1'b1; araddr = addr;
    check("ar_grant_on_push", {31'd0, ar_grant}, 32'd1);
    tick();
    exp_rd_q.push_back(addr[31:4]);
    arvalid = 1'b0; arready = 1'b0;
  endtask

  task automatic b_pull(input int n);
    bvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_wr_q.size() > 0) void'(exp_wr_q.pop_front());
    end
    bvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic r_last_pull(input int n);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_rd_q.size() > 0) void'(exp_rd_q.pop_front());
    end
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    // Reset then idle
    idle_inputs();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    arst = 1'b0;
    tick();
    check("rst_wr_cnt", 32'(wr_or_cnt), 32'd0);
    check("rst_rd_cnt", 32'(rd_or_cnt), 32'd0);
    check("rst_pending_wr", {31'd0, pending_wr}, 32'd0);
    check("rst_pending_rd", {31'd0, pending_rd}, 32'd0);
    check("rst_aw_grant", {31'd0, aw_grant}, 32'd1);
    check("rst_ar_grant", {31'd0, ar_grant}, 32'd1);
    check("rst_err", {31'd0, err}, 32'd0);

    // Fill the write table with 8 distinct blocks
    for (int i = 0; i < 8; i++) aw_push(32'h3000 + 32'(i) * 32'h10);
    check("full_wr_cnt", 32'(wr_or_cnt), 32'd8);
    check("full_wr_cnt_sb", 32'(wr_or_cnt), 32'(exp_wr_q.size()));
    check("full_pending_wr", {31'd0, pending_wr}, 32'd1);
    awaddr = 32'h3100;
    check("full_aw_grant", {31'd0, aw_grant}, 32'd0);
    b_pull(1);
    check("after_b_wr_cnt", 32'(wr_or_cnt), 32'd7);
    check("after_b_aw_grant", {31'd0, aw_grant}, 32'd1);
    b_pull(7);
    check("drain_wr_cnt", 32'(wr_or_cnt), 32'd0);
    check("drain_err", {31'd0, err}, 32'd0);

    // Read-after-write hazard on block 0x100
    aw_push(32'h1000);
    araddr = 32'h1008;
    #1;
    check("raw_same_block", {31'd0, ar_grant}, HAZ ? 32'd0 : 32'd1);
    araddr = 32'h1010;
    #1;
    check("raw_other_block", {31'd0, ar_grant}, 32'd1);
    araddr = 32'h1008;
    b_pull(1);
    check("raw_after_b", {31'd0, ar_grant}, 32'd1);

    // Write-after-read hazard on block 0x200
    ar_push(32'h2000);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b0;
    tick();
    rvalid = 1'b0; rready = 1'b0;
    check("war_rd_cnt_mid_burst", 32'(rd_or_cnt), 32'd1);
    awaddr = 32'h2004;
    #1;
    check("war_same_block", {31'd0, aw_grant}, HAZ ? 32'd0 : 32'd1);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    #1;
    check("war_on_pull_edge", {31'd0, aw_grant}, HAZ ? 32'd0 : 32'd1);
    tick();
    void'(exp_rd_q.pop_front());
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    check("war_after_rlast", {31'd0, aw_grant}, 32'd1);
    check("war_rd_cnt_after", 32'(rd_or_cnt), 32'd0);

    // Simultaneous AR push and R-last pull at count 4
    for (int i = 0; i < 4; i++) ar_push(32'h4000 + 32'(i) * 32'h10);
    check("rd_cnt_4", 32'(rd_or_cnt), 32'd4);
    arvalid = 1'b1; arready = 1'b1; araddr = 32'h5000;
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    tick();
    exp_rd_q.push_back(28'h500);
    void'(exp_rd_q.pop_front());
    idle_inputs();
    check("rd_cnt_push_pull", 32'(rd_or_cnt), 32'd4);
    check("rd_cnt_push_pull_sb", 32'(rd_or_cnt), 32'(exp_rd_q.size()));
    r_last_pull(4);
    check("rd_drain_cnt", 32'(rd_or_cnt), 32'd0);
    check("rd_drain_pending", {31'd0, pending_rd}, 32'd0);

    // Pointer wrap over 20 write transactions
    for (int i = 0; i < 20; i++) begin
      awvalid = 1'b1; awready = 1'b1; awaddr = 32'h6000 + 32'(i) * 32'h10;
      bvalid = (i > 0); bready = (i > 0);
      tick();
      exp_wr_q.push_back(awaddr[31:4]);
      if (i > 0) void'(exp_wr_q.pop_front());
    end
    idle_inputs();
    check("wrap_wr_cnt_1", 32'(wr_or_cnt), 32'd1);
    b_pull(1);
    check("wrap_wr_cnt_0", 32'(wr_or_cnt), 32'd0);
    check("wrap_err", {31'd0, err}, 32'd0);

    // Asynchronous reset mid-burst with three writes outstanding
    for (int i = 0; i < 3; i++) aw_push(32'h7000 + 32'(i) * 32'h10);
    check("pre_rst_wr_cnt", 32'(wr_or_cnt), 32'd3);
    awvalid = 1'b1; awready = 1'b1; awaddr = 32'h7030;
    #2;
    arst = 1'b1;
    #1;
    exp_wr_q.delete();
    check("mid_rst_wr_cnt", 32'(wr_or_cnt), 32'd0);
    check("mid_rst_pending_wr", {31'd0, pending_wr}, 32'd0);
    check("mid_rst_aw_grant", {31'd0, aw_grant}, 32'd1);
    check("mid_rst_ar_grant", {31'd0, ar_grant}, 32'd1);
    idle_inputs();
    @(negedge aclk);
    arst = 1'b0;
    tick();
    check("post_rst_wr_cnt", 32'(wr_or_cnt), 32'd0);

    // B handshake with the write table empty is a sticky error
    b_pull(1);
    check("underflow_err", {31'd0, err}, 32'd1);
    check("underflow_wr_cnt", 32'(wr_or_cnt), 32'd0);
    repeat (3) tick();
    check("underflow_err_held", {31'd0, err}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/friscv_axi_rsp_ordering.md
# friscv_axi_rsp_ordering

Responder-side AXI4 ordering guard, placed in front of the memory or peripheral slave that serves the memfy/cache AXI master. It tracks outstanding write and read transactions by cache-block address, from the address handshake until the response handshake. It gates new AW/AR requests when the tracking table is full or a read/write address hazard exists, and it reports occupancy and protocol errors.

## Interface
Parameters:
- MAX_OR, 8: maximum outstanding writes and, separately, maximum outstanding reads; power of two ≥ 2.
- AXI_ADDR_W, 32: AXI address width.
- MEM_BLOCK_W, 128: block width in bits; ADDR_LSB = clog2(MEM_BLOCK_W/8).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- arst  in  1  reset, asynchronous, active-high.
- awvalid / awready  in  1 each  slave-side AW handshake, after gating.
- awaddr  in  AXI_ADDR_W  write address.
- arvalid / arready  in  1 each  slave-side AR handshake, after gating.
- araddr  in  AXI_ADDR_W  read address.
- bvalid / bready  in  1 each  write response handshake.
- rvalid / rready / rlast  in  1 each  read data handshake.
- aw_grant  out  1  AW may be forwarded to the slave this cycle.
- ar_grant  out  1  AR may be forwarded to the slave this cycle.
- wr_or_cnt / rd_or_cnt  out  clog2(MAX_OR)+1  outstanding counts.
- pending_wr / pending_rd  out  1  count non-zero.
- err  out  1  sticky protocol-error flag.

## Operation
- Two tracking tables, write and read. Each has MAX_OR entries holding a valid bit and a block tag (addr[AXI_ADDR_W-1:ADDR_LSB]).
- Each table is managed as a circular FIFO with wr_ptr/rd_ptr of clog2(MAX_OR)+1 bits. The MSB distinguishes full from empty. The count equals wr_ptr − rd_ptr, modulo 2^(clog2(MAX_OR)+1).
- Push, write table: awvalid & awready. Store the tag at wr_ptr, set valid, advance wr_ptr.
- Push, read table: arvalid & arready.
- Pull, write table: bvalid & bready. Clear valid at rd_ptr, advance rd_ptr. Responses retire in issue order; single-ID, in-order slave.
- Pull, read table: rvalid & rready & rlast.
- A push and a pull on the same table in the same cycle: both occur, and the count is unchanged.
- aw_grant = !wr_full & !war_hit. war_hit is set when the awaddr tag matches any valid read entry.
- ar_grant = !rd_full & !raw_hit. raw_hit is set when the araddr tag matches any valid write entry.
- Hazard compares use registered table contents only. An entry pulled this cycle still counts as a hit this cycle.
- err is set, and held until reset, on any of:
  - a push while full (the push is dropped and pointers are unchanged);
  - a pull while empty (ignored).
- Reset, asserted at any time including mid-transaction:
  - pointers, valids and err clear immediately;
  - counts are 0, pending_* are 0, aw_grant = ar_grant = 1.
  - Outstanding transactions are forgotten; later responses count as pull-while-empty errors.

## Timing
- aw_grant and ar_grant are combinational from the incoming address and the registered table. There is no added latency: the request passes in the cycle the grant is high.
- Counts, pending flags and err are registered and update one cycle after the handshake.
- A full table frees an entry on the pull edge, so the grant reasserts in the next cycle.
- Same-cycle simultaneous AW and AR to the same block, with both tables empty: both are granted. Hazard coverage is for outstanding entries only.

## Configuration
- FRISCV_RSP_HAZARD_EN defined: war_hit and raw_hit are computed as above.
- FRISCV_RSP_HAZARD_EN undefined: war_hit = raw_hit = 0; grants depend only on full. The tag storage and compare logic are removed; valids and counters remain.

## Structure
- Shared package: the ADDR_LSB and tag-width computations, plus the typedef for a table entry (valid, tag).
- One sub-module, friscv_tag_fifo, instantiated twice:
  - circular FIFO with push/pull, full/empty/count and sticky overflow/underflow flags;
  - combinational seek port returning a hit against all valid entries.

## Test plan
- Reset then idle: all outputs at reset values. Assert arst mid-burst with count 3: count is 0 on the next edge and grants are high.
- Issue 8 writes to distinct blocks without responses (MAX_OR=8): wr_or_cnt=8 and aw_grant=0. One B handshake: next cycle count=7 and aw_grant=1.
- Write to 0x1000 outstanding, AR to 0x1008 (same block): ar_grant=0 until B. AR to 0x1010: ar_grant=1.
- Read to 0x2000 outstanding (no rlast yet), AW to 0x2004: aw_grant=0. rlast handshake: aw_grant=1 in the next cycle.
- With count 4, same-cycle AR push and R-last pull: rd_or_cnt stays 4. Pointer wrap exercised over 20 transactions with no err.
- bvalid&bready with the write table empty: err=1 and held. Repeat with FRISCV_RSP_HAZARD_EN undefined: same-block AR is granted.
